dcache_ctrl_nway: RTL and testbench

Control FSM for an N-way set-associative, write-back, write-allocate L1 data cache in the LC-3b memory hierarchy. It sits between the CPU-side memory port and physical memory, and drives the cache datapath arrays (data, tag, valid, dirty, PLRU). It generalises the single-way, single-beat controller in three ways: parametrised associativity, tree-PLRU victim selection with invalid-way preference, and multi-beat burst writeback and fill with a beat counter.

---
 rtl/dcache_ctrl_nway.sv | 231 +++++++++++++++++++++++
 tb/tb_dcache_ctrl_nway.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_nway.sv
// N-way write-back/write-allocate L1 D-cache control FSM with tree-PLRU and burst pmem.
// Optional perf counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl_nway #(
  parameter int NUM_WAYS    = 4,
  parameter int BURST_BEATS = 1,
  parameter int WAY_W       = $clog2(NUM_WAYS),
  parameter int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [NUM_WAYS-2:0] lru_bits,
  input  logic                pmem_resp,
  output logic                mem_resp,
  output logic [WAY_W-1:0]    way_sel,
  output logic [NUM_WAYS-1:0] data_we,
  output logic                data_src_sel,
  output logic                tag_update,
  output logic                valid_update,
  output logic                dirty_update,
  output logic                dirty_in,
  output logic                lru_write,
  output logic [NUM_WAYS-2:0] lru_next,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic                pmem_addr_sel,
  output logic [BEAT_W-1:0]   beat_idx
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hits,
  output logic [31:0]         perf_misses,
  output logic [31:0]         perf_writebacks
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WAY_W-1:0]    r_victim;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_hit_way;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_next;
  logic                w_req;
  logic                w_hit;
  logic                w_last;
  logic                w_vic_dirty;
  logic                w_latch;

  // Walk from the root: each bit picks the subtree, so the path spells the way index MSB first.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] b);
    int n;
    logic [WAY_W-1:0] v;
    n = 0;
    v = '0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = b[n];
      n = 2 * n + 1 + int'(b[n]);
    end
    return v;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(
    input logic [NUM_WAYS-2:0] b,
    input logic [WAY_W-1:0]    w
  );
    int n;
    logic d;
    logic [NUM_WAYS-2:0] r;
    n = 0;
    r = b;
    for (int l = 0; l < WAY_W; l++) begin
      d = w[WAY_W-1-l];
      r[n] = ~d;
      n = 2 * n + 1 + int'(d);
    end
    return r;
  endfunction

  assign w_req  = mem_read | mem_write;
  assign w_hit  = |hit_vec;
  assign w_last = (r_beat == LAST_BEAT);

  always_comb begin
    w_hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) w_hit_way = WAY_W'(i);
    end
  end

  // Invalid ways are free to fill; only a fully valid set consults PLRU.
  always_comb begin
    w_victim = plru_victim(lru_bits);
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) w_victim = WAY_W'(i);
    end
  end

  assign w_vic_dirty = valid_vec[w_victim] & dirty_vec[w_victim];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      r_beat  <= w_beat_next;
      if (w_latch) r_victim <= w_victim;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_beat_next   = r_beat;
    w_latch       = 1'b0;
    mem_resp      = 1'b0;
    way_sel       = '0;
    data_we       = '0;
    data_src_sel  = 1'b0;
    tag_update    = 1'b0;
    valid_update  = 1'b0;
    dirty_update  = 1'b0;
    dirty_in      = 1'b0;
    lru_write     = 1'b0;
    lru_next      = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    beat_idx      = '0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            mem_resp  = 1'b1;
            way_sel   = w_hit_way;
            lru_write = 1'b1;
            lru_next  = plru_touch(lru_bits, w_hit_way);
            if (mem_write) begin
              data_we      = NUM_WAYS'(1) << w_hit_way;
              data_src_sel = 1'b1;
              dirty_update = 1'b1;
              dirty_in     = 1'b1;
            end
          end else if (w_req) begin
            w_latch = 1'b1;
            w_next  = w_vic_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = r_victim;
          beat_idx      = r_beat;
          if (pmem_resp) begin
            if (w_last) begin
              w_beat_next  = '0;
              dirty_update = 1'b1;
              w_next       = S_FILL;
            end else begin
              w_beat_next = r_beat + 1'b1;
            end
          end
        end
        S_FILL: begin
          pmem_read = 1'b1;
          way_sel   = r_victim;
          beat_idx  = r_beat;
          if (pmem_resp) begin
            data_we = NUM_WAYS'(1) << r_victim;
            if (w_last) begin
              w_beat_next  = '0;
              tag_update   = 1'b1;
              valid_update = 1'b1;
              dirty_update = 1'b1;
              w_next       = S_IDLE;
            end else begin
              w_beat_next = r_beat + 1'b1;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  a_hit_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_state == S_IDLE && w_req) |-> $onehot0(hit_vec)
  );

`ifdef DCACHE_PERF_CNT_EN
  logic        w_idle_req;
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;
  logic [31:0] r_perf_wbs;

  assign w_idle_req = (r_state == S_IDLE) & w_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
      r_perf_wbs    <= '0;
    end else begin
      if (w_idle_req && w_hit && r_perf_hits != '1)
        r_perf_hits <= r_perf_hits + 32'd1;
      if (w_idle_req && !w_hit && r_perf_misses != '1)
        r_perf_misses <= r_perf_misses + 32'd1;
      if (w_idle_req && !w_hit && w_vic_dirty && r_perf_wbs != '1)
        r_perf_wbs <= r_perf_wbs + 32'd1;
    end
  end

  assign perf_hits       = r_perf_hits;
  assign perf_misses     = r_perf_misses;
  assign perf_writebacks = r_perf_wbs;
`endif

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Self-checking bench for dcache_ctrl_nway (4 ways, 4-beat bursts).
// Expected output bundles are queued as stimulus is applied and popped on sampling.
module tb_dcache_ctrl_nway;

  localparam int NW = 4;
  localparam int BB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_read, mem_write, pmem_resp;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [2:0] lru_bits;
  logic       mem_resp, data_src_sel, tag_update, valid_update;
  logic       dirty_update, dirty_in, lru_write;
  logic       pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0] way_sel, beat_idx;
  logic [3:0] data_we;
  logic [2:0] lru_next;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses, perf_writebacks;
`endif

  int checks = 0;
  int errors = 0;
  logic [20:0] sb_q[$];
  logic [20:0] exp_v;
  logic [20:0] obs;

  always #5 clk = ~clk;

  dcache_ctrl_nway #(.NUM_WAYS(NW), .BURST_BEATS(BB)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .hit_vec(hit_vec), .valid_vec(valid_vec),
    .dirty_vec(dirty_vec), .lru_bits(lru_bits),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .way_sel(way_sel), .data_we(data_we),
    .data_src_sel(data_src_sel), .tag_update(tag_update),
    .valid_update(valid_update), .dirty_update(dirty_update),
    .dirty_in(dirty_in), .lru_write(lru_write),
    .lru_next(lru_next), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .beat_idx(beat_idx)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses),
    .perf_writebacks(perf_writebacks)
`endif
  );

  assign obs = {mem_resp, way_sel, data_we, data_src_sel,
                tag_update, valid_update, dirty_update, dirty_in,
                lru_write, lru_next, pmem_read, pmem_write,
                pmem_addr_sel, beat_idx};

  function automatic logic [20:0] mk(
    input logic resp, input logic [1:0] ws, input logic [3:0] we,
    input logic src, input logic tag, input logic val,
    input logic dup, input logic din, input logic lw,
    input logic [2:0] ln, input logic pr, input logic pw,
    input logic pas, input logic [1:0] bi);
    return {resp, ws, we, src, tag, val, dup, din, lw, ln,
            pr, pw, pas, bi};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1;
    hit_vec = 4'b0001; valid_vec = 4'b1111; pmem_resp = 1'b1;
    #2;
    checks++;
    if (obs !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 21'd0);
    end
    mem_read = 1'b0; mem_write = 1'b0; hit_vec = 4'b0; pmem_resp = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    pmem_resp = 1'b1;
    #2;
    checks++;
    if (obs !== 21'd0) begin
      errors++;
      $display("FAIL idle_pmem_ignored got=%h exp=%h", obs, 21'd0);
    end
    cyc();
    pmem_resp = 1'b0;
    #2;
    checks++;
    if (obs !== 21'd0) begin
      errors++;
      $display("FAIL idle_after_resp got=%h exp=%h", obs, 21'd0);
    end
  endtask

  task automatic test_read_hit();
    cyc();
    mem_read = 1'b1; hit_vec = 4'b0100;
    valid_vec = 4'b1111; lru_bits = 3'b000;
    sb_q.push_back(mk(1, 2'd2, 4'b0, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0, 2'd0));
    #2;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL read_hit got=%h exp=%h", obs, exp_v);
    end
    cyc();
    mem_read = 1'b0; hit_vec = 4'b0;
  endtask

  task automatic test_write_hit();
    cyc();
    mem_write = 1'b1; hit_vec = 4'b0001; lru_bits = 3'b000;
    sb_q.push_back(mk(1, 2'd0, 4'b0001, 1, 0, 0, 1, 1, 1, 3'b011, 0, 0, 0, 2'd0));
    #2;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL write_hit got=%h exp=%h", obs, exp_v);
    end
    cyc();
    mem_write = 1'b0; hit_vec = 4'b0;
  endtask

  task automatic test_clean_miss();
    logic sched [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic last;
    int b;
    cyc();
    mem_read = 1'b1; hit_vec = 4'b0;
    valid_vec = 4'b1011; dirty_vec = 4'b1111; lru_bits = 3'b000;
    #2;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL clean_miss_detect got=%b%b exp=00", mem_resp, pmem_read);
    end
    cyc();
    b = 0;
    foreach (sched[k]) begin
      pmem_resp = sched[k];
      last = sched[k] && (b == BB - 1);
      sb_q.push_back(mk(0, 2'd2, sched[k] ? 4'b0100 : 4'b0000, 0,
                        last, last, last, 0, 0, 3'b000, 1, 0, 0, 2'(b)));
      #2;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_fill_%0d got=%h exp=%h", k, obs, exp_v);
      end
      if (sched[k]) b++;
      cyc();
    end
    pmem_resp = 1'b0;
    hit_vec = 4'b0100; valid_vec = 4'b1111;
    sb_q.push_back(mk(1, 2'd2, 4'b0, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0, 2'd0));
    #2;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL clean_rehit got=%h exp=%h", obs, exp_v);
    end
    cyc();
    mem_read = 1'b0; hit_vec = 4'b0;
  endtask

  task automatic test_dirty_miss();
    logic last;
    cyc();
    mem_read = 1'b1; mem_write = 1'b1; hit_vec = 4'b0;
    valid_vec = 4'b1111; dirty_vec = 4'b1111; lru_bits = 3'b101;
    #2;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL dirty_miss_detect got=%b exp=0", mem_resp);
    end
    cyc();
    valid_vec = 4'b0000; lru_bits = 3'b000;
    for (int b = 0; b < 2 * BB; b++) begin
      pmem_resp = 1'b1;
      last = ((b % BB) == BB - 1);
      if (b < BB)
        sb_q.push_back(mk(0, 2'd3, 4'b0, 0, 0, 0, last, 0, 0, 3'b000,
                          0, 1, 1, 2'(b % BB)));
      else
        sb_q.push_back(mk(0, 2'd3, 4'b1000, 0, last, last, last, 0, 0,
                          3'b000, 1, 0, 0, 2'(b % BB)));
      #2;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL dirty_burst_%0d got=%h exp=%h", b, obs, exp_v);
      end
      checks++;
      if ((pmem_read & pmem_write) !== 1'b0) begin
        errors++;
        $display("FAIL pmem_overlap_%0d got=1 exp=0", b);
      end
      cyc();
    end
    pmem_resp = 1'b0;
    hit_vec = 4'b1000; valid_vec = 4'b1111; lru_bits = 3'b101;
    sb_q.push_back(mk(1, 2'd3, 4'b1000, 1, 0, 0, 1, 1, 1, 3'b000, 0, 0, 0, 2'd0));
    #2;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dirty_rehit got=%h exp=%h", obs, exp_v);
    end
    cyc();
    mem_read = 1'b0; mem_write = 1'b0; hit_vec = 4'b0;
  endtask

  task automatic test_reset_mid_fill();
    cyc();
    mem_read = 1'b1; hit_vec = 4'b0;
    valid_vec = 4'b0000; dirty_vec = 4'b0000; lru_bits = 3'b000;
    cyc();
    for (int b = 0; b < 2; b++) begin
      pmem_resp = 1'b1;
      sb_q.push_back(mk(0, 2'd0, 4'b0001, 0, 0, 0, 0, 0, 0, 3'b000,
                        1, 0, 0, 2'(b)));
      #2;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rst_fill_%0d got=%h exp=%h", b, obs, exp_v);
      end
      cyc();
    end
    pmem_resp = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_fill got=%h exp=%h", obs, 21'd0);
    end
    cyc();
    pmem_resp = 1'b0; mem_read = 1'b0;
    rst_n = 1'b1;
    cyc();
    mem_read = 1'b1;
    cyc();
    sb_q.push_back(mk(0, 2'd0, 4'b0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 2'd0));
    #2;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL refill_beat0 got=%h exp=%h", obs, exp_v);
    end
    rst_n = 1'b0;
    mem_read = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    valid_vec = 4'b1111; dirty_vec = 4'b0000; lru_bits = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      mem_read = 1'b1; hit_vec = 4'(1 << i);
      cyc();
      mem_read = 1'b0; hit_vec = 4'b0;
    end
    mem_read = 1'b1; valid_vec = 4'b0000;
    cyc();
    pmem_resp = 1'b1;
    repeat (BB) cyc();
    pmem_resp = 1'b0; hit_vec = 4'b0001; valid_vec = 4'b1111;
    cyc();
    hit_vec = 4'b0; dirty_vec = 4'b1111;
    cyc();
    pmem_resp = 1'b1;
    repeat (2 * BB) cyc();
    pmem_resp = 1'b0; hit_vec = 4'b0001;
    cyc();
    mem_read = 1'b0; hit_vec = 4'b0;
    #2;
    checks++;
    if (perf_hits !== 32'd5) begin
      errors++;
      $display("FAIL perf_hits got=%0d exp=5", perf_hits);
    end
    checks++;
    if (perf_misses !== 32'd2) begin
      errors++;
      $display("FAIL perf_misses got=%0d exp=2", perf_misses);
    end
    checks++;
    if (perf_writebacks !== 32'd1) begin
      errors++;
      $display("FAIL perf_writebacks got=%0d exp=1", perf_writebacks);
    end
  endtask
`endif

  initial begin
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit_vec = 4'b0; valid_vec = 4'b0; dirty_vec = 4'b0;
    lru_bits = 3'b0;
    repeat (2) cyc();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_fill();
`ifdef DCACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
